// File: rtl/sid_audio_pkg.sv
// sid_audio_pkg: shared types and helpers for the SID audio output stage.
// FSM encoding, the filter state width and the 16-bit clamp.
package sid_audio_pkg;

  localparam int Y_W = 24;

  typedef enum logic [1:0] {
    ACC,
    FILT,
    PUSH
  } state_t;

  function automatic logic signed [15:0] sat16(
    input logic signed [23:0] v
  );
    if (v > 24'sd32767) begin
      return 16'sh7fff;
    end else if (v < -24'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/sid_audio_fifo.sv
// sid_audio_fifo: small synchronous FIFO for 16-bit audio samples.
// Head is presented from registered state; reads as 0 when empty.
module sid_audio_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic [15:0] din,
  input  logic        pop,
  output logic [15:0] dout,
  output logic        empty,
  output logic        full
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop frees the slot the same cycle, so a full FIFO still accepts
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? 16'h0000 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sid_audio_decim.sv
// sid_audio_decim: boxcar decimator, optional DC blocker, 16-bit clamp
// and output FIFO feeding the audio serializer.
module sid_audio_decim
  import sid_audio_pkg::*;
#(
  parameter int DECIM      = 32,
  parameter int DC_SHIFT   = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [17:0] audio_in,
  input  logic        dc_en,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow
);

  localparam int LOG2D = $clog2(DECIM);
  localparam int ACC_W = 18 + LOG2D;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic [LOG2D-1:0]        cnt;
  logic                    blk_done;
  logic signed [17:0]      x;
  logic signed [17:0]      x_prev;
  logic signed [17:0]      x_prev_d;
  logic signed [Y_W-1:0]   y;
  logic signed [Y_W-1:0]   y_d;
  logic signed [Y_W-1:0]   y_new;
  logic signed [Y_W-1:0]   x_ext;
  logic signed [Y_W-1:0]   xp_ext;
  logic signed [15:0]      res;
  logic signed [15:0]      res_d;
  state_t                  state_q;
  state_t                  state_d;
  logic                    push;
  logic                    empty;
  logic                    full;

  assign acc_sum  = acc + {{LOG2D{audio_in[17]}}, audio_in};
  assign blk_done = in_valid && (cnt == LOG2D'(DECIM - 1));

  // runs regardless of FSM state so no input sample is ever lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
      x   <= '0;
    end else if (in_valid) begin
      if (blk_done) begin
        acc <= '0;
        cnt <= '0;
        x   <= acc_sum[ACC_W-1:LOG2D];
      end else begin
        acc <= acc_sum;
        cnt <= cnt + LOG2D'(1);
      end
    end
  end

  assign x_ext  = {{(Y_W-18){x[17]}}, x};
  assign xp_ext = {{(Y_W-18){x_prev[17]}}, x_prev};
  assign y_new  = y + x_ext - xp_ext - (y >>> DC_SHIFT);

  always_comb begin
    state_d  = state_q;
    y_d      = y;
    x_prev_d = x_prev;
    res_d    = res;
    push     = 1'b0;
    unique case (state_q)
      ACC: begin
        if (blk_done) begin
          state_d = FILT;
        end
      end
      FILT: begin
        x_prev_d = x;
        if (dc_en) begin
          y_d   = y_new;
          res_d = sat16(y_new >>> 2);
        end else begin
          y_d   = '0;
          res_d = sat16(x_ext >>> 2);
        end
        state_d = PUSH;
      end
      PUSH: begin
        push    = 1'b1;
        state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ACC;
      y       <= '0;
      x_prev  <= '0;
      res     <= '0;
    end else begin
      state_q <= state_d;
      y       <= y_d;
      x_prev  <= x_prev_d;
      res     <= res_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (push && full && !out_ready) begin
      overflow <= 1'b1;
    end
  end

  sid_audio_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (res),
    .pop     (out_ready),
    .dout    (out_data),
    .empty   (empty),
    .full    (full)
  );

  assign out_valid = ~empty;

endmodule
